// File: rtl/stage_rt_nway_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stage_rt_nway_pkg
// Description : Shared types and constants for the N-wide retire stage.
// Revision    : 1.0 - initial release
// ============================================================================
package stage_rt_nway_pkg;

  localparam int RT_WIDTH_DEF = 3;
  localparam int ZERO_REG     = 0;

  typedef enum logic [1:0] {
    RT_RUN    = 2'd0,
    RT_SQUASH = 2'd1,
    RT_DRAIN  = 2'd2,
    RT_HALTED = 2'd3
  } rt_state_t;

endpackage : stage_rt_nway_pkg
`default_nettype wire

// File: rtl/stage_rt_nway_prefix_mask.sv
`default_nettype none
// ============================================================================
// Module      : rt_prefix_mask
// Description : In-order retire prefix: mask, terminator one-hot/kind, count.
// Revision    : 1.0 - initial release
// ============================================================================
module rt_prefix_mask
  import stage_rt_nway_pkg::*;
#(
  parameter int RT_WIDTH = RT_WIDTH_DEF
) (
  input  logic                             enable,
  input  logic [RT_WIDTH-1:0]              valid,
  input  logic [RT_WIDTH-1:0]              take_branch,
  input  logic [RT_WIDTH-1:0]              halt_in,
  output logic [RT_WIDTH-1:0]              retire_mask,
  output logic [RT_WIDTH-1:0]              term_onehot,
  output logic                             term_any,
  output logic                             term_is_halt,
  output logic [$clog2(RT_WIDTH+1)-1:0]    ack_count
);

  localparam int CNT_BITS = $clog2(RT_WIDTH+1);

  logic w_open;

  // The window stays open until a gap or a retired terminator closes it.
  always_comb begin
    retire_mask  = '0;
    term_onehot  = '0;
    term_is_halt = 1'b0;
    ack_count    = '0;
    w_open       = enable;
    for (int i = 0; i < RT_WIDTH; i++) begin
      if (w_open && valid[i]) begin
        retire_mask[i] = 1'b1;
        ack_count      = ack_count + CNT_BITS'(1);
        if (take_branch[i] || halt_in[i]) begin
          term_onehot[i] = 1'b1;
          term_is_halt   = halt_in[i];
          w_open         = 1'b0;
        end
      end else begin
        w_open = 1'b0;
      end
    end
  end

  assign term_any = |term_onehot;

endmodule : rt_prefix_mask
`default_nettype wire

// File: rtl/stage_rt_nway.sv
`default_nettype none
// ============================================================================
// Module      : stage_rt_nway
// Description : N-wide in-order retire stage with squash/halt-drain FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_rt_nway
  import stage_rt_nway_pkg::*;
#(
  parameter int RT_WIDTH = RT_WIDTH_DEF,
  parameter int XLEN     = 32,
  parameter int REG_W    = 5,
  parameter int TAG_W    = 5,
  parameter int CNT_W    = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [RT_WIDTH-1:0]           rob_valid,
  input  logic [RT_WIDTH*REG_W-1:0]     rob_dest_reg,
  input  logic [RT_WIDTH*TAG_W-1:0]     rob_tag,
  input  logic [RT_WIDTH*XLEN-1:0]      rob_value,
  input  logic [RT_WIDTH*XLEN-1:0]      rob_npc,
  input  logic [RT_WIDTH-1:0]           rob_take_branch,
  input  logic [RT_WIDTH-1:0]           rob_halt,
  input  logic                          rt_busy,
  output logic [RT_WIDTH-1:0]           rf_wr_en,
  output logic [RT_WIDTH*REG_W-1:0]     rf_wr_idx,
  output logic [RT_WIDTH*XLEN-1:0]      rf_wr_data,
  output logic [RT_WIDTH-1:0]           mt_retire_valid,
  output logic [RT_WIDTH*TAG_W-1:0]     mt_retire_tag,
  output logic [RT_WIDTH-1:0]           lsq_retire_valid,
  output logic [RT_WIDTH*TAG_W-1:0]     lsq_retire_tag,
  output logic [RT_WIDTH-1:0]           retire_valid,
  output logic [RT_WIDTH*XLEN-1:0]      retire_npc,
  output logic [$clog2(RT_WIDTH+1)-1:0] rob_ack_count,
  output logic                          squash_flag,
  output logic [XLEN-1:0]               squash_pc,
  output logic                          halt,
  output logic [CNT_W-1:0]              retired_count
);

  localparam logic [REG_W-1:0] c_zero_reg = REG_W'(ZERO_REG);

  rt_state_t                      r_state;
  logic                           r_squash_flag;
  logic [XLEN-1:0]                r_squash_pc;
  logic                           r_halt;
  logic [CNT_W-1:0]               r_retired_count;

  logic                           w_run;
  logic [RT_WIDTH-1:0]            w_mask;
  logic [RT_WIDTH-1:0]            w_term_onehot;
  logic                           w_term_any;
  logic                           w_term_is_halt;
  logic [$clog2(RT_WIDTH+1)-1:0]  w_ack_count;
  logic [XLEN-1:0]                w_term_value;

  assign w_run = (r_state == RT_RUN);

  rt_prefix_mask #(
    .RT_WIDTH (RT_WIDTH)
  ) u_prefix (
    .enable       (w_run),
    .valid        (rob_valid),
    .take_branch  (rob_take_branch),
    .halt_in      (rob_halt),
    .retire_mask  (w_mask),
    .term_onehot  (w_term_onehot),
    .term_any     (w_term_any),
    .term_is_halt (w_term_is_halt),
    .ack_count    (w_ack_count)
  );

  always_comb begin
    w_term_value = '0;
    for (int i = 0; i < RT_WIDTH; i++) begin
      if (w_term_onehot[i]) begin
        w_term_value = rob_value[i*XLEN +: XLEN];
      end
    end
  end

  generate
    for (genvar g = 0; g < RT_WIDTH; g++) begin : g_slot
      logic w_has_dest;
      assign w_has_dest = (rob_dest_reg[g*REG_W +: REG_W] != c_zero_reg);

      assign retire_valid[g]     = w_mask[g];
      assign rf_wr_en[g]         = w_mask[g] &&  w_has_dest;
      assign mt_retire_valid[g]  = w_mask[g] &&  w_has_dest;
      assign lsq_retire_valid[g] = w_mask[g] && !w_has_dest;

      assign rf_wr_idx[g*REG_W +: REG_W]      = w_run ? rob_dest_reg[g*REG_W +: REG_W] : '0;
      assign rf_wr_data[g*XLEN +: XLEN]       = !w_run ? '0 :
                                                rob_take_branch[g] ? rob_npc[g*XLEN +: XLEN]
                                                                   : rob_value[g*XLEN +: XLEN];
      assign mt_retire_tag[g*TAG_W +: TAG_W]  = w_run ? rob_tag[g*TAG_W +: TAG_W] : '0;
      assign lsq_retire_tag[g*TAG_W +: TAG_W] = w_run ? rob_tag[g*TAG_W +: TAG_W] : '0;
      assign retire_npc[g*XLEN +: XLEN]       = w_run ? rob_npc[g*XLEN +: XLEN] : '0;
    end
  endgenerate

  assign rob_ack_count = w_ack_count;

  // Halt wins over take_branch on the same terminator: no squash is raised.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= RT_RUN;
      r_squash_flag   <= 1'b0;
      r_squash_pc     <= '0;
      r_halt          <= 1'b0;
      r_retired_count <= '0;
    end else begin
      r_retired_count <= r_retired_count + CNT_W'(w_ack_count);
      case (r_state)
        RT_RUN: begin
          if (w_term_any) begin
            if (w_term_is_halt) begin
              r_state <= RT_DRAIN;
            end else begin
              r_state       <= RT_SQUASH;
              r_squash_flag <= 1'b1;
              r_squash_pc   <= w_term_value;
            end
          end
        end
        RT_SQUASH: begin
          r_state       <= RT_RUN;
          r_squash_flag <= 1'b0;
        end
        RT_DRAIN: begin
          if (!rt_busy) begin
            r_state <= RT_HALTED;
            r_halt  <= 1'b1;
          end
        end
        RT_HALTED: begin
          r_halt <= 1'b1;
        end
        default: begin
          r_state <= RT_RUN;
        end
      endcase
    end
  end

  assign squash_flag   = r_squash_flag;
  assign squash_pc     = r_squash_pc;
  assign halt          = r_halt;
  assign retired_count = r_retired_count;

endmodule : stage_rt_nway
`default_nettype wire

// File: tb/tb_stage_rt_nway.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_rt_nway
// Description : Directed self-checking bench for the N-wide retire stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_rt_nway;

  localparam int RT_WIDTH = 3;
  localparam int XLEN     = 32;
  localparam int REG_W    = 5;
  localparam int TAG_W    = 5;
  localparam int CNT_W    = 64;

  logic                          clock;
  logic                          reset;
  logic [RT_WIDTH-1:0]           rob_valid;
  logic [RT_WIDTH*REG_W-1:0]     rob_dest_reg;
  logic [RT_WIDTH*TAG_W-1:0]     rob_tag;
  logic [RT_WIDTH*XLEN-1:0]      rob_value;
  logic [RT_WIDTH*XLEN-1:0]      rob_npc;
  logic [RT_WIDTH-1:0]           rob_take_branch;
  logic [RT_WIDTH-1:0]           rob_halt;
  logic                          rt_busy;
  logic [RT_WIDTH-1:0]           rf_wr_en;
  logic [RT_WIDTH*REG_W-1:0]     rf_wr_idx;
  logic [RT_WIDTH*XLEN-1:0]      rf_wr_data;
  logic [RT_WIDTH-1:0]           mt_retire_valid;
  logic [RT_WIDTH*TAG_W-1:0]     mt_retire_tag;
  logic [RT_WIDTH-1:0]           lsq_retire_valid;
  logic [RT_WIDTH*TAG_W-1:0]     lsq_retire_tag;
  logic [RT_WIDTH-1:0]           retire_valid;
  logic [RT_WIDTH*XLEN-1:0]      retire_npc;
  logic [$clog2(RT_WIDTH+1)-1:0] rob_ack_count;
  logic                          squash_flag;
  logic [XLEN-1:0]               squash_pc;
  logic                          halt;
  logic [CNT_W-1:0]              retired_count;

  int checks = 0;
  int errors = 0;

  stage_rt_nway #(
    .RT_WIDTH (RT_WIDTH),
    .XLEN     (XLEN),
    .REG_W    (REG_W),
    .TAG_W    (TAG_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .rob_valid        (rob_valid),
    .rob_dest_reg     (rob_dest_reg),
    .rob_tag          (rob_tag),
    .rob_value        (rob_value),
    .rob_npc          (rob_npc),
    .rob_take_branch  (rob_take_branch),
    .rob_halt         (rob_halt),
    .rt_busy          (rt_busy),
    .rf_wr_en         (rf_wr_en),
    .rf_wr_idx        (rf_wr_idx),
    .rf_wr_data       (rf_wr_data),
    .mt_retire_valid  (mt_retire_valid),
    .mt_retire_tag    (mt_retire_tag),
    .lsq_retire_valid (lsq_retire_valid),
    .lsq_retire_tag   (lsq_retire_tag),
    .retire_valid     (retire_valid),
    .retire_npc       (retire_npc),
    .rob_ack_count    (rob_ack_count),
    .squash_flag      (squash_flag),
    .squash_pc        (squash_pc),
    .halt             (halt),
    .retired_count    (retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_inputs();
    rob_valid       = '0;
    rob_dest_reg    = '0;
    rob_tag         = '0;
    rob_value       = '0;
    rob_npc         = '0;
    rob_take_branch = '0;
    rob_halt        = '0;
    rt_busy         = 1'b0;
  endtask

  task automatic set_slot(input int i, input logic [REG_W-1:0] dest, input logic [TAG_W-1:0] tag,
                          input logic [XLEN-1:0] value, input logic [XLEN-1:0] npc,
                          input logic tb, input logic hl);
    rob_valid[i]                   = 1'b1;
    rob_dest_reg[i*REG_W +: REG_W] = dest;
    rob_tag[i*TAG_W +: TAG_W]      = tag;
    rob_value[i*XLEN +: XLEN]      = value;
    rob_npc[i*XLEN +: XLEN]        = npc;
    rob_take_branch[i]             = tb;
    rob_halt[i]                    = hl;
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    #1 reset = 1'b0;
    #6;
    check("rst_squash_flag", 64'(squash_flag), 64'd0);
    check("rst_squash_pc", 64'(squash_pc), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_count", retired_count, 64'd0);
    #5 reset = 1'b1;
    tick();

    // All three slots valid, plain ALU results.
    set_slot(0, 5'd1, 5'd11, 32'hA0, 32'h04, 1'b0, 1'b0);
    set_slot(1, 5'd2, 5'd12, 32'hA1, 32'h08, 1'b0, 1'b0);
    set_slot(2, 5'd3, 5'd13, 32'hA2, 32'h0C, 1'b0, 1'b0);
    #1;
    check("full_wr_en", 64'(rf_wr_en), 64'h7);
    check("full_retire", 64'(retire_valid), 64'h7);
    check("full_ack", 64'(rob_ack_count), 64'd3);
    check("full_lsq", 64'(lsq_retire_valid), 64'h0);
    check("full_idx2", 64'(rf_wr_idx[2*REG_W +: REG_W]), 64'd3);
    check("full_data1", 64'(rf_wr_data[1*XLEN +: XLEN]), 64'hA1);
    check("full_mttag2", 64'(mt_retire_tag[2*TAG_W +: TAG_W]), 64'd13);
    tick();
    check("full_count", retired_count, 64'd3);

    // Gap in slot 1 blocks slot 2.
    rob_valid = 3'b101;
    #1;
    check("gap_retire", 64'(retire_valid), 64'h1);
    check("gap_ack", 64'(rob_ack_count), 64'd1);
    check("gap_wr_en", 64'(rf_wr_en), 64'h1);
    tick();
    check("gap_count", retired_count, 64'd4);

    // Oldest slot missing: nothing retires.
    rob_valid = 3'b110;
    #1;
    check("head_gap_retire", 64'(retire_valid), 64'h0);
    check("head_gap_ack", 64'(rob_ack_count), 64'd0);

    // Slot 1 is a taken branch: slots 0..1 retire, slot 2 is cut off.
    clear_inputs();
    set_slot(0, 5'd2, 5'd1, 32'hB0, 32'h20, 1'b0, 1'b0);
    set_slot(1, 5'd1, 5'd2, 32'h1000, 32'h24, 1'b1, 1'b0);
    set_slot(2, 5'd3, 5'd3, 32'hB2, 32'h28, 1'b0, 1'b0);
    #1;
    check("br_retire", 64'(retire_valid), 64'h3);
    check("br_ack", 64'(rob_ack_count), 64'd2);
    check("br_data1", 64'(rf_wr_data[1*XLEN +: XLEN]), 64'h24);
    check("br_npc1", 64'(retire_npc[1*XLEN +: XLEN]), 64'h24);
    tick();
    check("sq_flag", 64'(squash_flag), 64'd1);
    check("sq_pc", 64'(squash_pc), 64'h1000);
    check("sq_retire", 64'(retire_valid), 64'h0);
    check("sq_ack", 64'(rob_ack_count), 64'd0);
    check("sq_count", retired_count, 64'd6);
    rob_valid = '0;
    tick();
    check("post_sq_flag", 64'(squash_flag), 64'd0);
    check("post_sq_pc", 64'(squash_pc), 64'h1000);
    check("post_sq_count", retired_count, 64'd6);
    rob_valid       = 3'b111;
    rob_take_branch = '0;
    #1;
    check("post_sq_retire", 64'(retire_valid), 64'h7);
    rob_valid = '0;

    // Store in slot 0, halt in slot 2, store path busy for four cycles.
    clear_inputs();
    set_slot(0, 5'd0, 5'd4, 32'hC0, 32'h40, 1'b0, 1'b0);
    set_slot(1, 5'd4, 5'd5, 32'hC1, 32'h44, 1'b0, 1'b0);
    set_slot(2, 5'd5, 5'd6, 32'hC2, 32'h48, 1'b0, 1'b1);
    rt_busy = 1'b1;
    #1;
    check("hl_lsq", 64'(lsq_retire_valid), 64'h1);
    check("hl_lsq_tag0", 64'(lsq_retire_tag[0 +: TAG_W]), 64'd4);
    check("hl_retire", 64'(retire_valid), 64'h7);
    check("hl_wr_en", 64'(rf_wr_en), 64'h6);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("drain_halt", 64'(halt), 64'd0);
      check("drain_retire", 64'(retire_valid), 64'h0);
      check("drain_sq", 64'(squash_flag), 64'd0);
    end
    check("drain_count", retired_count, 64'd9);
    rt_busy = 1'b0;
    tick();
    check("halted_halt", 64'(halt), 64'd1);
    tick();
    check("halted_sticky", 64'(halt), 64'd1);
    check("halted_retire", 64'(retire_valid), 64'h0);
    check("halted_count", retired_count, 64'd9);

    // Async reset clears the halt without a clock edge.
    #2 reset = 1'b0;
    #1;
    check("arst_halt", 64'(halt), 64'd0);
    check("arst_count", retired_count, 64'd0);
    #3 reset = 1'b1;

    // Halt and take_branch together in slot 0: halt wins, no squash.
    clear_inputs();
    set_slot(0, 5'd0, 5'd7, 32'h3000, 32'h50, 1'b1, 1'b1);
    set_slot(1, 5'd1, 5'd8, 32'hD1, 32'h54, 1'b0, 1'b0);
    #1;
    check("hb_retire", 64'(retire_valid), 64'h1);
    check("hb_ack", 64'(rob_ack_count), 64'd1);
    tick();
    check("hb_sq_flag", 64'(squash_flag), 64'd0);
    check("hb_sq_pc", 64'(squash_pc), 64'd0);
    check("hb_halt_early", 64'(halt), 64'd0);
    check("hb_retire_drain", 64'(retire_valid), 64'h0);
    check("hb_count", retired_count, 64'd1);
    rob_valid = '0;
    tick();
    check("hb_halt", 64'(halt), 64'd1);

    #2 reset = 1'b0;
    #3 reset = 1'b1;

    // Async reset in the middle of SQUASH.
    clear_inputs();
    set_slot(0, 5'd7, 5'd9, 32'h2000, 32'h08, 1'b1, 1'b0);
    #1;
    check("sq2_retire", 64'(retire_valid), 64'h1);
    tick();
    check("sq2_flag", 64'(squash_flag), 64'd1);
    check("sq2_pc", 64'(squash_pc), 64'h2000);
    check("sq2_count", retired_count, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_sq_flag", 64'(squash_flag), 64'd0);
    check("arst_sq_pc", 64'(squash_pc), 64'd0);
    check("arst_sq_count", retired_count, 64'd0);
    #2 reset = 1'b1;
    clear_inputs();
    set_slot(0, 5'd1, 5'd1, 32'hE0, 32'h60, 1'b0, 1'b0);
    set_slot(1, 5'd2, 5'd2, 32'hE1, 32'h64, 1'b0, 1'b0);
    set_slot(2, 5'd3, 5'd3, 32'hE2, 32'h68, 1'b0, 1'b0);
    #1;
    check("resume_retire", 64'(retire_valid), 64'h7);
    tick();
    check("resume_count", retired_count, 64'd3);
    check("resume_sq_flag", 64'(squash_flag), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_stage_rt_nway
`default_nettype wire
